// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle of the fifo write arbiter: per-producer request/data in,
// one-hot grant and done/err pulses back.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;

  modport master (output req, output req_data, input gnt, input done, input err);
  modport slave  (input req, input req_data, output gnt, output done, output err);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of the fifo write port among NREQ producers; one fifo
// write per grant, with the fifo's ack/err returned as a done/err pulse.
//
// state | meaning
// IDLE  | waiting for a request while the fifo is not full
// WRITE | fifo_wr_en high for this single cycle
// CHECK | fifo ack/err valid, sampled at the end of the cycle
// RESP  | done or err pulse to the granted producer
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  fifo_wr_arbiter_if.slave prod,
  output logic            busy,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_din,
  input  logic            fifo_full,
  input  logic            fifo_wr_ack,
  input  logic            fifo_wr_err
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, CHECK, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   g;
  logic [PW-1:0]   sel;
  logic            sel_vld;
  logic [NREQ-1:0] sel_onehot;
  logic [PW-1:0]   rr_next;
  logic            resp_ok;
  logic            resp_bad;
  int              idx;

  // First requester found scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_vld && prod.req[idx]) begin
        sel_vld = 1'b1;
        sel     = PW'(idx);
      end
    end
  end

  assign sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel;
  assign rr_next    = (g == PW'(NREQ-1)) ? '0 : g + 1'b1;
  // A missing ack counts as a rejection, whether or not wr_err was raised.
  assign resp_ok    = fifo_wr_ack;
  assign resp_bad   = fifo_wr_err | ~fifo_wr_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      g          <= '0;
      prod.gnt   <= '0;
      prod.done  <= '0;
      prod.err   <= '0;
      busy       <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      case (state)
        IDLE: begin
          prod.done <= '0;
          prod.err  <= '0;
          if (sel_vld && !fifo_full) begin
            g          <= sel;
            prod.gnt   <= sel_onehot;
            fifo_wr_en <= 1'b1;
            fifo_din   <= prod.req_data[int'(sel)*DW +: DW];
            busy       <= 1'b1;
            state      <= WRITE;
          end else begin
            prod.gnt   <= '0;
            fifo_wr_en <= 1'b0;
          end
        end
        WRITE: begin
          fifo_wr_en <= 1'b0;
          state      <= CHECK;
        end
        CHECK: begin
          if (resp_ok)       prod.done <= prod.gnt;
          else if (resp_bad) prod.err  <= prod.gnt;
          rr_ptr <= rr_next;
          state  <= RESP;
        end
        RESP: begin
          prod.done <= '0;
          prod.err  <= '0;
          prod.gnt  <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: 8-deep fifo model, directed table of grants,
// full/reset corner sequences and randomized transactions against a model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  logic          busy, fifo_wr_en, fifo_full, fifo_wr_ack, fifo_wr_err;
  logic [DW-1:0] fifo_din;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .prod        (bus.slave),
    .busy        (busy),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .fifo_full   (fifo_full),
    .fifo_wr_ack (fifo_wr_ack),
    .fifo_wr_err (fifo_wr_err)
  );

  // fifo model; mode 0 normal, 1 reject with wr_err, 2 reject with no flag
  logic [DW-1:0] mem [8];
  logic [2:0]    wp, rp;
  int            cnt;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  int            fifo_mode;
  logic          do_w, do_r;

  assign do_w      = fifo_wr_en && (fifo_mode == 0) && (cnt < 8);
  assign do_r      = rd_en && (cnt > 0);
  assign fifo_full = (fifo_mode == 0) && (cnt == 8);

  always @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0; rp <= '0; cnt <= 0; fifo_wr_ack <= 1'b0; fifo_wr_err <= 1'b0; rd_data <= '0;
    end else begin
      fifo_wr_ack <= 1'b0;
      fifo_wr_err <= 1'b0;
      if (fifo_wr_en) begin
        if (fifo_mode == 0 && cnt < 8) fifo_wr_ack <= 1'b1;
        else if (fifo_mode != 2)       fifo_wr_err <= 1'b1;
      end
      if (do_w) begin mem[wp] <= fifo_din; wp <= wp + 3'd1; end
      if (do_r) begin rd_data <= mem[rp]; rp <= rp + 3'd1; end
      cnt <= cnt + int'(do_w) - int'(do_r);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] prod_data [NREQ];
  logic [DW-1:0] exp_q [$];
  int m_rr;

  typedef struct {
    logic [NREQ-1:0] req;
    int              exp_sel;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [NREQ-1:0] r);
    bus.req = r;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = prod_data[i];
  endtask

  // Reference: first requester at or after rr in rotation order
  function automatic int pick(input logic [NREQ-1:0] m, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset;
    reset_n = 1'b0; rd_en = 1'b0; fifo_mode = 0;
    drive_req('0);
    step; step;
    chk("reset_ctl", {bus.gnt, bus.done, bus.err, busy, fifo_wr_en}, 0);
    chk("reset_din", fifo_din, 0);
    reset_n = 1'b1;
    m_rr = 0;
    exp_q.delete();
  endtask

  // Current cycle is IDLE with requests driven; walks cycles 1..4.
  task automatic run_txn(input int sel, input bit ok, input bit rereq);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << sel;
    chk("c0_busy", busy, 0);
    step;
    chk("c1_gnt", bus.gnt, oh);
    chk("c1_wr_en", fifo_wr_en, 1);
    chk("c1_din", fifo_din, prod_data[sel]);
    chk("c1_busy", busy, 1);
    step;
    chk("c2_wr_en", fifo_wr_en, 0);
    chk("c2_gnt", bus.gnt, oh);
    chk("c2_resp", {bus.done, bus.err}, 0);
    step;
    chk("c3_done", bus.done, ok ? oh : '0);
    chk("c3_err", bus.err, ok ? '0 : oh);
    chk("c3_gnt_wr", {bus.gnt, fifo_wr_en}, {oh, 1'b0});
    if (!rereq) bus.req[sel] = 1'b0;
    if (ok) exp_q.push_back(prod_data[sel]);
    m_rr = (sel + 1) % NREQ;
    step;
    chk("c4_idle", {bus.gnt, bus.done, bus.err, busy, fifo_wr_en}, 0);
  endtask

  logic [NREQ-1:0] pend, nw;
  int sel, mode;
  bit ok, rereq;

  initial begin
    tbl[0] = '{4'b1111, 0}; tbl[1] = '{4'b1111, 1};
    tbl[2] = '{4'b1111, 2}; tbl[3] = '{4'b1111, 3};
    tbl[4] = '{4'b0101, 0}; tbl[5] = '{4'b0101, 2};
    tbl[6] = '{4'b0101, 0}; tbl[7] = '{4'b0101, 2};
    for (int i = 0; i < NREQ; i++) prod_data[i] = '0;
    bus.req = '0; bus.req_data = '0; rd_en = 1'b0; fifo_mode = 0;

    // single producer
    do_reset;
    prod_data[0] = 32'hA5A5_0001;
    drive_req(4'b0001);
    run_txn(0, 1'b1, 1'b0);
    chk("t1_count", cnt, 1);

    // rotation table, ends with the fifo full
    do_reset;
    for (int i = 0; i < NREQ; i++) prod_data[i] = 32'h1000_0000 + DW'(i);
    for (int v = 0; v < 8; v++) begin
      drive_req(tbl[v].req);
      run_txn(tbl[v].exp_sel, 1'b1, 1'b0);
    end
    chk("t2_full", fifo_full, 1);

    // full fifo holds off the grant until a read frees a slot
    drive_req(4'b0010);
    repeat (5) begin
      step;
      chk("t4_hold", {bus.gnt, fifo_wr_en, busy}, 0);
    end
    rd_en = 1'b1;
    step;
    rd_en = 1'b0;
    chk("t4_rd_head", rd_data, exp_q.pop_front());
    run_txn(1, 1'b1, 1'b0);
    chk("t4_count", cnt, 8);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step;
      chk("drain_data", rd_data, exp_q.pop_front());
    end
    rd_en = 1'b0;
    chk("drain_count", cnt, 0);

    // reset during WRITE, then during CHECK
    do_reset;
    drive_req(4'b1111);
    run_txn(0, 1'b1, 1'b0);
    step;
    chk("t6_w_gnt", bus.gnt, 4'b0010);
    reset_n = 1'b0;
    step;
    chk("t6_w_rst", {bus.gnt, bus.done, bus.err, busy, fifo_wr_en}, 0);
    reset_n = 1'b1; m_rr = 0; exp_q.delete();
    drive_req(4'b1111);
    run_txn(0, 1'b1, 1'b0);
    step; step;
    reset_n = 1'b0;
    step;
    chk("t6_c_rst", {bus.gnt, bus.done, bus.err, busy, fifo_wr_en}, 0);
    reset_n = 1'b1; m_rr = 0; exp_q.delete();
    drive_req(4'b1111);
    run_txn(0, 1'b1, 1'b0);

    // randomized producers, fifo drained continuously, random rejections
    do_reset;
    rd_en = 1'b1;
    pend = '0;
    for (int n = 0; n < 60; n++) begin
      nw = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~pend;
      for (int i = 0; i < NREQ; i++) if (nw[i]) prod_data[i] = $urandom;
      pend = pend | nw;
      if (pend == '0) begin
        drive_req('0);
        step;
        chk("rnd_idle", {bus.gnt, busy, fifo_wr_en}, 0);
        continue;
      end
      mode = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
      fifo_mode = mode;
      sel   = pick(pend, m_rr);
      ok    = (mode == 0);
      rereq = !ok && ($urandom_range(0, 1) == 1);
      drive_req(pend);
      run_txn(sel, ok, rereq);
      if (!rereq) pend[sel] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
